// File: rtl/cpu_csr_unit.sv
// cpu_csr_unit: Zicsr read-modify-write initiator toward the CSR file.
module cpu_csr_unit #(
    parameter bit RO_CHECK = 1'b1,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [11:0]     csr_addr,
    input  logic [4:0]      rs1_field,
    input  logic [XLEN-1:0] rs1_val,
    output logic            busy,
    output logic            done,
    output logic            illegal,
    output logic [XLEN-1:0] rd_val,
    output logic [11:0]     csr_addr_out,
    output logic [XLEN-1:0] csr_data_out,
    output logic            csr_wr,
    input  logic [XLEN-1:0] csr_data_in,
    output logic            incr_inst_count
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t state, state_nx;
    logic [2:0] f3;
    logic [4:0] rs1f;
    logic [XLEN-1:0] rs1v, old, src, nv;
    logic ill, we, ro, bad;
    always_comb begin
        src = f3[2] ? {{(XLEN-5){1'b0}}, rs1f} : rs1v;
        nv = (f3[1:0] == 2'b01) ? src : (f3[1:0] == 2'b10) ? (csr_data_in | src) : (csr_data_in & ~src);
        we = (f3[1:0] == 2'b01) || (rs1f != 5'd0);
        ro = RO_CHECK && we && (csr_addr_out[11:10] == 2'b11);
        bad = funct3[1:0] == 2'b00;
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? (bad ? DONE : READ) : IDLE;
            READ:    state_nx = ro ? DONE : WRITE;
            WRITE:   state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end
    assign busy            = state != IDLE;
    assign done            = state == DONE;
    assign illegal         = done && ill;
    assign incr_inst_count = done && !ill;
    assign csr_wr          = (state == WRITE) && we;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            f3           <= '0;
            rs1f         <= '0;
            rs1v         <= '0;
            csr_addr_out <= '0;
            old          <= '0;
            ill          <= 1'b0;
            rd_val       <= '0;
            csr_data_out <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                f3           <= funct3;
                csr_addr_out <= csr_addr;
                rs1f         <= rs1_field;
                rs1v         <= rs1_val;
                ill          <= bad;
            end
            if (state == READ) begin
                old <= csr_data_in;
                ill <= ro;
                if (we && !ro)
                    csr_data_out <= nv;
            end
            // Only a completed write path returns the old value; illegal outcomes return zero.
            if (state_nx == DONE)
                rd_val <= (state == WRITE) ? old : '0;
        end
    end
endmodule
